// File: rtl/reg_operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : reg_operand_fetch
//  Brief    : Operand-fetch requester for the two register-file read ports.
//             Accepts one instruction at a time, reads its source registers,
//             bypasses same-cycle and held-operand writes, and presents the
//             operands downstream on a valid/ready output.
//  Revision : 1.0  initial release
// ============================================================================
module reg_operand_fetch #(
  parameter int WIDTH        = 32,
  parameter int REG_ADDR_LEN = 5,
  parameter int TAG_W        = 8,
  parameter int TIMEOUT      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // instruction input
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [REG_ADDR_LEN-1:0] in_ra,
  input  logic [REG_ADDR_LEN-1:0] in_rb,
  input  logic                    in_use_a,
  input  logic                    in_use_b,
  input  logic [TAG_W-1:0]        in_tag,
  // register-file read ports
  output logic [REG_ADDR_LEN-1:0] ra,
  output logic [REG_ADDR_LEN-1:0] rb,
  output logic                    r_en_A,
  output logic                    r_en_B,
  input  logic [WIDTH-1:0]        dataA,
  input  logic [WIDTH-1:0]        dataB,
  input  logic                    st_A,
  input  logic                    st_B,
  // snooped register-file write port
  input  logic [REG_ADDR_LEN-1:0] wb_rc,
  input  logic [WIDTH-1:0]        wb_data,
  input  logic                    wb_en,
  // operand output
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_a,
  output logic [WIDTH-1:0]        out_b,
  output logic [TAG_W-1:0]        out_tag,
  output logic                    err_timeout
);

  // Wide enough to hold TIMEOUT-1 (the last WAIT cycle index)
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] C_LAST_WAIT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [REG_ADDR_LEN-1:0] ra_q, ra_d;
  logic [REG_ADDR_LEN-1:0] rb_q, rb_d;
  logic                    use_a_q, use_a_d;
  logic                    use_b_q, use_b_d;
  logic [TAG_W-1:0]        tag_q, tag_d;
  logic                    got_a_q, got_a_d;
  logic                    got_b_q, got_b_d;
  logic                    r_en_a_q, r_en_a_d;
  logic                    r_en_b_q, r_en_b_d;
  logic [WIDTH-1:0]        out_a_q, out_a_d;
  logic [WIDTH-1:0]        out_b_q, out_b_d;
  logic                    out_valid_q, out_valid_d;
  logic                    err_q, err_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  // Captured operand value: R0 reads as zero; a write to the same register
  // in the capture cycle wins because the register file commits it after
  // its own read.
  function automatic logic [WIDTH-1:0] pick_operand(
    input logic [REG_ADDR_LEN-1:0] addr,
    input logic [WIDTH-1:0]        rd_data,
    input logic                    byp_en,
    input logic [REG_ADDR_LEN-1:0] byp_addr,
    input logic [WIDTH-1:0]        byp_data
  );
    if (addr == '0) begin
      pick_operand = '0;
    end else if (byp_en && (byp_addr == addr)) begin
      pick_operand = byp_data;
    end else begin
      pick_operand = rd_data;
    end
  endfunction

  logic [WIDTH-1:0] w_val_a;
  logic [WIDTH-1:0] w_val_b;
  logic             w_cap_a;
  logic             w_cap_b;
  logic             w_done_a;
  logic             w_done_b;
  logic             w_wb_nz;
  logic             w_hold_hit_a;
  logic             w_hold_hit_b;

  assign w_val_a  = pick_operand(ra_q, dataA, wb_en, wb_rc, wb_data);
  assign w_val_b  = pick_operand(rb_q, dataB, wb_en, wb_rc, wb_data);
  // A strobe only counts for an operand that is still outstanding
  assign w_cap_a  = use_a_q & ~got_a_q & st_A;
  assign w_cap_b  = use_b_q & ~got_b_q & st_B;
  assign w_done_a = got_a_q | w_cap_a;
  assign w_done_b = got_b_q | w_cap_b;
  // Held operands follow writes to their (nonzero) source register
  assign w_wb_nz      = wb_en & (wb_rc != '0);
  assign w_hold_hit_a = w_wb_nz & use_a_q & (wb_rc == ra_q);
  assign w_hold_hit_b = w_wb_nz & use_b_q & (wb_rc == rb_q);

  // Next-state and next-output computation for the fetch sequencer
  always_comb begin
    state_d     = state_q;
    ra_d        = ra_q;
    rb_d        = rb_q;
    use_a_d     = use_a_q;
    use_b_d     = use_b_q;
    tag_d       = tag_q;
    got_a_d     = got_a_q;
    got_b_d     = got_b_q;
    r_en_a_d    = r_en_a_q;
    r_en_b_d    = r_en_b_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_valid_d = out_valid_q;
    err_d       = 1'b0;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          ra_d    = in_ra;
          rb_d    = in_rb;
          use_a_d = in_use_a;
          use_b_d = in_use_b;
          tag_d   = in_tag;
          // Unused operands are already "captured" and read as zero
          got_a_d = ~in_use_a;
          got_b_d = ~in_use_b;
          out_a_d = '0;
          out_b_d = '0;
          cnt_d   = '0;
          if (in_use_a || in_use_b) begin
            state_d  = S_READ;
            r_en_a_d = in_use_a;
            r_en_b_d = in_use_b;
          end else begin
            state_d     = S_HOLD;
            out_valid_d = 1'b1;
          end
        end
      end

      S_READ, S_WAIT: begin
        if (w_cap_a) begin
          out_a_d = w_val_a;
        end
        if (w_cap_b) begin
          out_b_d = w_val_b;
        end
        got_a_d = w_done_a;
        got_b_d = w_done_b;

        if (w_done_a && w_done_b) begin
          state_d     = S_HOLD;
          out_valid_d = 1'b1;
          r_en_a_d    = 1'b0;
          r_en_b_d    = 1'b0;
        end else if ((state_q == S_WAIT) && (cnt_q == C_LAST_WAIT)) begin
          // Abandon the missing operand(s) and deliver what we have
          if (!w_done_a) begin
            out_a_d = '0;
          end
          if (!w_done_b) begin
            out_b_d = '0;
          end
          got_a_d     = 1'b1;
          got_b_d     = 1'b1;
          state_d     = S_HOLD;
          out_valid_d = 1'b1;
          r_en_a_d    = 1'b0;
          r_en_b_d    = 1'b0;
          err_d       = 1'b1;
        end else begin
          state_d  = S_WAIT;
          r_en_a_d = ~w_done_a;
          r_en_b_d = ~w_done_b;
          cnt_d    = (state_q == S_WAIT) ? (cnt_q + CNT_W'(1)) : '0;
        end
      end

      S_HOLD: begin
        if (out_ready) begin
          // Any write seen in the handshake cycle belongs to a younger instruction
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          if (w_hold_hit_a) begin
            out_a_d = wb_data;
          end
          if (w_hold_hit_b) begin
            out_b_d = wb_data;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ra_q        <= '0;
      rb_q        <= '0;
      use_a_q     <= 1'b0;
      use_b_q     <= 1'b0;
      tag_q       <= '0;
      got_a_q     <= 1'b0;
      got_b_q     <= 1'b0;
      r_en_a_q    <= 1'b0;
      r_en_b_q    <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      use_a_q     <= use_a_d;
      use_b_q     <= use_b_d;
      tag_q       <= tag_d;
      got_a_q     <= got_a_d;
      got_b_q     <= got_b_d;
      r_en_a_q    <= r_en_a_d;
      r_en_b_q    <= r_en_b_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign ra          = ra_q;
  assign rb          = rb_q;
  assign r_en_A      = r_en_a_q;
  assign r_en_B      = r_en_b_q;
  assign out_valid   = out_valid_q;
  assign out_a       = out_a_q;
  assign out_b       = out_b_q;
  assign out_tag     = tag_q;
  assign err_timeout = err_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_operand_fetch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_reg_operand_fetch
//  Brief    : Self-checking bench for reg_operand_fetch with a negedge
//             register-file model, directed vector table, corner sequences
//             and randomized transactions against a reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reg_operand_fetch;

  localparam int WIDTH   = 32;
  localparam int RAL     = 5;
  localparam int TAG_W   = 8;
  localparam int TIMEOUT = 4;
  localparam int NEVER   = 255;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [RAL-1:0]   in_ra, in_rb;
  logic             in_use_a, in_use_b;
  logic [TAG_W-1:0] in_tag;
  logic [RAL-1:0]   ra, rb;
  logic             r_en_A, r_en_B;
  logic [WIDTH-1:0] dataA, dataB;
  logic             st_A, st_B;
  logic [RAL-1:0]   wb_rc;
  logic [WIDTH-1:0] wb_data;
  logic             wb_en;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] out_a, out_b;
  logic [TAG_W-1:0] out_tag;
  logic             err_timeout;

  int checks = 0;
  int errors = 0;

  // register-file model state
  logic [WIDTH-1:0] mem [32];
  int dly_a = 0, dly_b = 0;
  int cnt_a = 0, cnt_b = 0;

  typedef struct {
    logic [RAL-1:0]   ra, rb;
    logic             ua, ub;
    logic [TAG_W-1:0] tag;
    int               dly_a, dly_b;
    logic             wen;
    logic [RAL-1:0]   wrc;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] exp_a, exp_b;
    int               exp_err;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  reg_operand_fetch #(
    .WIDTH(WIDTH), .REG_ADDR_LEN(RAL), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ra(in_ra), .in_rb(in_rb), .in_use_a(in_use_a), .in_use_b(in_use_b),
    .in_tag(in_tag),
    .ra(ra), .rb(rb), .r_en_A(r_en_A), .r_en_B(r_en_B),
    .dataA(dataA), .dataB(dataB), .st_A(st_A), .st_B(st_B),
    .wb_rc(wb_rc), .wb_data(wb_data), .wb_en(wb_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_tag(out_tag),
    .err_timeout(err_timeout)
  );

  // Register file commits writes at posedge, after the negedge read
  always @(posedge clk) begin
    if (wb_en) mem[wb_rc] <= wb_data;
  end

  // Register file read side: strobe after a per-port delay of enabled cycles
  always @(negedge clk) begin
    if (r_en_A) begin
      if (cnt_a == dly_a) begin st_A = 1'b1; dataA = mem[ra]; end
      else begin st_A = 1'b0; dataA = $urandom; end
      cnt_a = cnt_a + 1;
    end else begin
      cnt_a = 0; st_A = 1'b0; dataA = $urandom;
    end
    if (r_en_B) begin
      if (cnt_b == dly_b) begin st_B = 1'b1; dataB = mem[rb]; end
      else begin st_B = 1'b0; dataB = $urandom; end
      cnt_b = cnt_b + 1;
    end else begin
      cnt_b = 0; st_B = 1'b0; dataB = $urandom;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [RAL-1:0] a, b, input logic ua, ub,
                              input logic [TAG_W-1:0] tag, input int da, db,
                              input logic wen, input logic [RAL-1:0] wrc,
                              input logic [WIDTH-1:0] wd, ea, eb, input int ee);
    vec_t v;
    v.ra = a; v.rb = b; v.ua = ua; v.ub = ub; v.tag = tag;
    v.dly_a = da; v.dly_b = db; v.wen = wen; v.wrc = wrc; v.wdata = wd;
    v.exp_a = ea; v.exp_b = eb; v.exp_err = ee;
    return v;
  endfunction

  task automatic wr(input logic [RAL-1:0] a, input logic [WIDTH-1:0] d);
    wb_en = 1'b1; wb_rc = a; wb_data = d;
    step();
    wb_en = 1'b0;
  endtask

  task automatic issue(input logic [RAL-1:0] a, b, input logic ua, ub, input logic [TAG_W-1:0] tag);
    int n = 0;
    while (!in_ready && n < 20) begin step(); n++; end
    chk("issue_ready", in_ready, 1);
    in_valid = 1'b1; in_ra = a; in_rb = b; in_use_a = ua; in_use_b = ub; in_tag = tag;
    step();
    in_valid = 1'b0;
  endtask

  // One full transaction. The model tracks each operand's register value
  // until its strobe is captured, then only while the output is stalled.
  task automatic run_txn(input vec_t v, input bit rnd,
                         output logic [WIDTH-1:0] act_a, act_b, output logic [TAG_W-1:0] act_tag,
                         output logic [WIDTH-1:0] mod_a, mod_b, output int errs, output bit done);
    int n = 0;
    logic [WIDTH-1:0] ea, eb;
    errs = 0; done = 1'b0; act_a = '0; act_b = '0; act_tag = '0; mod_a = '0; mod_b = '0;
    while (!in_ready && n < 20) begin step(); n++; end
    dly_a = v.dly_a; dly_b = v.dly_b;
    in_valid = 1'b1; in_ra = v.ra; in_rb = v.rb; in_use_a = v.ua; in_use_b = v.ub; in_tag = v.tag;
    wb_en = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    wb_rc = RAL'($urandom_range(0, 7)); wb_data = $urandom;
    step();
    in_valid = 1'b0;
    ea = mem[v.ra]; eb = mem[v.rb];
    for (int c = 1; c < 40 && !done; c++) begin
      if (err_timeout) errs++;
      if (rnd) begin
        wb_en = 1'($urandom_range(0, 1)); wb_rc = RAL'($urandom_range(0, 7));
        wb_data = $urandom; out_ready = ($urandom_range(0, 9) < 6);
      end else begin
        wb_en = (c == 1) && v.wen; wb_rc = v.wrc; wb_data = v.wdata; out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        act_a = out_a; act_b = out_b; act_tag = out_tag;
        mod_a = (v.ua && v.ra != '0) ? ea : '0;
        mod_b = (v.ub && v.rb != '0) ? eb : '0;
        done = 1'b1;
      end else if (wb_en) begin
        if (wb_rc == v.ra && (c <= 1 + v.dly_a || out_valid)) ea = wb_data;
        if (wb_rc == v.rb && (c <= 1 + v.dly_b || out_valid)) eb = wb_data;
      end
      step();
    end
    wb_en = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] aa, ab, ma, mb, ca, cb;
    logic [TAG_W-1:0] at, ct;
    logic [RAL-1:0]   sra, srb;
    int errs, ena, enb, vc, vcount, n;
    bit done;
    vec_t v;

    rst_n = 1'b0; in_valid = 1'b0; in_ra = '0; in_rb = '0; in_use_a = 1'b0; in_use_b = 1'b0;
    in_tag = '0; wb_en = 1'b0; wb_rc = '0; wb_data = '0; out_ready = 1'b0;
    repeat (3) step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_r_en", {r_en_A, r_en_B}, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_outs", {out_a, out_b, out_tag}, 0);
    rst_n = 1'b1;
    step();

    for (int k = 1; k < 8; k++) wr(RAL'(k), 32'h100 + k);
    wr(5'd0, 32'hDEAD);

    // ra  rb  ua ub tag   dA dB     wen rc  wdata    expA      expB     err
    vecs[0] = mk(3, 7, 1, 1, 8'h5A, 0, 0,     0, 0, 32'h0,    32'h103,  32'h107, 0);
    vecs[1] = mk(4, 5, 1, 1, 8'h11, 0, 0,     1, 4, 32'hBEEF, 32'hBEEF, 32'h105, 0);
    vecs[2] = mk(0, 2, 1, 1, 8'h22, 0, 0,     1, 0, 32'h77,   32'h0,    32'h102, 0);
    vecs[3] = mk(1, 2, 0, 0, 8'h33, 0, 0,     0, 0, 32'h0,    32'h0,    32'h0,   0);
    vecs[4] = mk(6, 6, 1, 0, 8'h44, 0, 0,     0, 0, 32'h0,    32'h106,  32'h0,   0);
    vecs[5] = mk(1, 2, 1, 1, 8'h55, 2, 0,     0, 0, 32'h0,    32'h101,  32'h102, 0);
    vecs[6] = mk(1, 3, 1, 1, 8'h66, 0, 4,     0, 0, 32'h0,    32'h101,  32'h103, 0);
    vecs[7] = mk(2, 3, 1, 1, 8'h77, 0, NEVER, 0, 0, 32'h0,    32'h102,  32'h0,   1);
    vecs[8] = mk(5, 5, 1, 1, 8'h88, 1, 3,     1, 5, 32'h55,   32'h55,   32'h55,  0);
    vecs[9] = mk(7, 4, 1, 1, 8'h99, 0, 0,     1, 4, 32'h44,   32'h107,  32'h44,  0);

    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i], 1'b0, aa, ab, at, ma, mb, errs, done);
      chk($sformatf("vec%0d_done", i), done, 1);
      chk($sformatf("vec%0d_a", i), aa, vecs[i].exp_a);
      chk($sformatf("vec%0d_b", i), ab, vecs[i].exp_b);
      chk($sformatf("vec%0d_tag", i), at, vecs[i].tag);
      chk($sformatf("vec%0d_err", i), errs, vecs[i].exp_err);
    end

    // Basic read timing: one-cycle read enables, output two cycles after accept
    dly_a = 0; dly_b = 0;
    wr(5'd3, 32'h11); wr(5'd7, 32'h22);
    issue(5'd3, 5'd7, 1'b1, 1'b1, 8'h5A);
    out_ready = 1'b1;
    ena = 0; enb = 0; vc = -1; vcount = 0; sra = ra; srb = rb;
    ca = '0; cb = '0; ct = '0;
    for (int c = 1; c < 8; c++) begin
      if (r_en_A) ena++;
      if (r_en_B) enb++;
      if (out_valid) begin
        vcount++;
        if (vc < 0) begin vc = c; ca = out_a; cb = out_b; ct = out_tag; end
      end
      step();
    end
    out_ready = 1'b0;
    chk("basic_addr", {sra, srb}, {5'd3, 5'd7});
    chk("basic_ren_a_cycles", ena, 1);
    chk("basic_ren_b_cycles", enb, 1);
    chk("basic_valid_latency", vc, 2);
    chk("basic_valid_cycles", vcount, 1);
    chk("basic_out", {ca, cb, ct}, {32'h11, 32'h22, 8'h5A});

    // HOLD update under backpressure; handshake-cycle write is ignored
    wr(5'd9, 32'h9);
    issue(5'd9, 5'd1, 1'b1, 1'b1, 8'h3C);
    n = 0;
    while (!out_valid && n < 10) begin step(); n++; end
    chk("hold_valid", out_valid, 1);
    chk("hold_a_initial", out_a, 32'h9);
    wb_en = 1'b1; wb_rc = 5'd9; wb_data = 32'hCAFE;
    step();
    wb_en = 1'b0;
    chk("hold_a_updated", out_a, 32'hCAFE);
    chk("hold_valid_stall1", out_valid, 1);
    step();
    chk("hold_valid_stall2", out_valid, 1);
    chk("hold_ab", {out_a, out_b, out_tag}, {32'hCAFE, 32'h101, 8'h3C});
    out_ready = 1'b1; wb_en = 1'b1; wb_rc = 5'd9; wb_data = 32'hBAD;
    step();
    out_ready = 1'b0; wb_en = 1'b0;
    chk("hold_accepted", out_valid, 0);
    chk("hold_no_late_write", out_a, 32'hCAFE);

    // Timeout with B never strobed
    dly_a = 0; dly_b = NEVER;
    issue(5'd2, 5'd3, 1'b1, 1'b1, 8'hC3);
    out_ready = 1'b1;
    ena = 0; enb = 0; errs = 0; vc = -1; ca = '0; cb = '1;
    for (int c = 1; c < 14; c++) begin
      if (r_en_A) ena++;
      if (r_en_B) enb++;
      if (err_timeout) errs++;
      if (out_valid && vc < 0) begin vc = c; ca = out_a; cb = out_b; end
      step();
    end
    out_ready = 1'b0; dly_b = 0;
    chk("to_ren_a_cycles", ena, 1);
    chk("to_ren_b_cycles", enb, 1 + TIMEOUT);
    chk("to_err_pulses", errs, 1);
    chk("to_valid_latency", vc, 2 + TIMEOUT);
    chk("to_out_a", ca, 32'h102);
    chk("to_out_b", cb, 32'h0);

    // Reset in the middle of a stalled fetch
    dly_b = NEVER;
    issue(5'd1, 5'd2, 1'b1, 1'b1, 8'hE1);
    step(); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_r_en", {r_en_A, r_en_B}, 0);
    chk("mid_rst_err", err_timeout, 0);
    errs = 0; vcount = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (err_timeout) errs++;
      if (out_valid || !in_ready) vcount++;
      step();
    end
    out_ready = 1'b0; dly_b = 0;
    chk("mid_rst_no_err", errs, 0);
    chk("mid_rst_stays_idle", vcount, 0);
    run_txn(mk(3, 7, 1, 1, 8'h42, 0, 1, 0, 0, 0, 32'h11, 32'h22, 0), 1'b0, aa, ab, at, ma, mb, errs, done);
    chk("post_rst_done", done, 1);
    chk("post_rst_out", {aa, ab, at}, {32'h11, 32'h22, 8'h42});

    // Randomized transactions against the reference model
    for (int i = 0; i < 200; i++) begin
      v = mk(RAL'($urandom_range(0, 7)), RAL'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), TAG_W'($urandom),
             $urandom_range(0, TIMEOUT), $urandom_range(0, TIMEOUT), 0, 0, 0, 0, 0, 0);
      run_txn(v, 1'b1, aa, ab, at, ma, mb, errs, done);
      chk($sformatf("rnd%0d_done", i), done, 1);
      chk($sformatf("rnd%0d_a", i), aa, ma);
      chk($sformatf("rnd%0d_b", i), ab, mb);
      chk($sformatf("rnd%0d_tag", i), at, v.tag);
      chk($sformatf("rnd%0d_err", i), errs, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
